br_resolve: RTL
===============

# br_resolve

Branch resolution unit: the execute-end partner of the fetch-stage branch predictor. It carries each fetched instruction's prediction (taken flag, predicted target, table index) through a 2-entry shadow pipeline that tracks IF/ID and ID/EX. In EX it compares the prediction with the real outcome, then raises flush/redirect on a mispredict and drives the predictor's registered training port (`br`, `brTaken`, `update_br_target`, `w_index`, `pr_correct`). Saturating hit/miss counters are provided for performance tuning.

## Interface
- `CNT_W`, 16, width of performance counters
- `CLK`  in  1  clock
- `nRST`  in  1  reset, asynchronous, active-low
- `stall`  in  1  pipeline hold; shadow pipeline and resolution frozen
- `if_valid`  in  1  fetch stage holds a real instruction this cycle
- `if_pc`  in  32  PC of fetched instruction
- `if_take_br`  in  1  predictor's taken prediction
- `if_br_target`  in  32  predictor's target
- `if_index`  in  2  predictor table index
- `ex_is_branch`  in  1  instruction in EX is a conditional branch
- `ex_br_taken`  in  1  actual outcome
- `ex_br_target`  in  32  computed branch target
- `flush`  out  1  kill IF/ID and ID/EX contents (combinational)
- `redirect_pc`  out  32  correct next PC, valid when `flush`=1
- `br`  out  1  predictor update strobe (registered)
- `brTaken`  out  1  actual outcome for update
- `update_br_target`  out  32  target to write into predictor
- `w_index`  out  2  predictor entry to update
- `pr_correct`  out  1  prediction was correct
- `cnt_clr`  in  1  synchronous clear of both counters
- `br_count`  out  CNT_W  resolved branches
- `miss_count`  out  CNT_W  mispredicted branches

## Operation
- Shadow pipeline: stages DE and EX, each holding {valid, pc, take, target, index}.
- Advance when `stall`=0: DE <= IF inputs (valid=`if_valid`); EX <= DE.
- When `stall`=1: both stages hold, and no resolution occurs.
- `fire` = EX.valid & `ex_is_branch` & !`stall`.
- `mispredict` = `fire` & ((EX.take != `ex_br_taken`) | (`ex_br_taken` & EX.take & EX.target != `ex_br_target`)).
- `flush` = `mispredict`.
- `redirect_pc` = `ex_br_taken` ? `ex_br_target` : EX.pc + 4 (32-bit wrap); outputs 0 when `flush`=0.
- On a flush edge: DE.valid <= 0 and EX.valid <= 0. Incoming IF data that cycle is discarded, since it is wrong-path.
- Update register, loaded every cycle:
  - `br` <= `fire`
  - `brTaken` <= `ex_br_taken`
  - `update_br_target` <= `ex_br_target`
  - `w_index` <= EX.index
  - `pr_correct` <= !`mispredict`
  - The data fields are don't-care when `br`=0, but the bench checks them only when `br`=1.
- Counters:
  - On `fire`, `br_count`+1.
  - On `mispredict`, `miss_count`+1.
  - Both saturate at 2^CNT_W−1.
  - `cnt_clr` has priority over increment.
- Non-branch instructions in EX cause no update and no flush, whatever their prediction fields hold.

## Timing
- Reset values: all stage valids 0, `br`=0, `brTaken`=0, `pr_correct`=0, `w_index`=0, `update_br_target`=0, counters 0. `flush`=0 follows from the valids being 0.
- IF to EX resolution: 2 un-stalled cycles after fetch.
- `flush`/`redirect_pc`: same cycle as resolution.
- Predictor update: `br` pulses exactly 1 cycle after resolution, for 1 cycle per branch, even if `stall` rises that cycle.
- Reset mid-operation: all in-flight predictions are dropped and no update is issued.
- Back-to-back branches each produce their own `br` pulse on consecutive cycles.
- A branch behind a mispredicted one is flushed and never updates.

## Test plan
- Reset, then idle: all outputs 0, counters 0, with no `br` pulse for 10 cycles.
- Correct not-taken: fetch pc=0x100, take=0, index=1; 2 cycles later EX branch with taken=0. Expect `flush`=0, next cycle `br`=1, `pr_correct`=1, `w_index`=1, `br_count`=1.
- Direction mispredict: pc=0x200, take=0; actual taken, target=0x240. Expect `flush`=1, `redirect_pc`=0x240, DE bubble next cycle, then `br`=1, `brTaken`=1, `pr_correct`=0, `miss_count`=1.
- Target mispredict: take=1, target=0x300; actual taken, target 0x310. Expect `flush`=1, `redirect_pc`=0x310.
- Predicted-taken-not-taken: pc=0x400 predicted taken, actual not taken. Expect `redirect_pc`=0x404.
- Stall during a resolving branch: 3-cycle `stall` with EX holding a branch gives no `flush`, `br` or count change. After release, exactly one resolution and one `br` pulse.
- Counter saturation with CNT_W=2: 5 mispredicts leave both counters at 3; `cnt_clr` sets them to 0.

Source files
------------

// File: rtl/br_resolve_if.sv
// Signal bundle between the core pipeline and the branch resolution unit:
// fetch-side prediction, EX-side outcome, flush/redirect and predictor training port.
interface br_resolve_if;
  logic        stall;
  logic        if_valid;
  logic [31:0] if_pc;
  logic        if_take_br;
  logic [31:0] if_br_target;
  logic [1:0]  if_index;
  logic        ex_is_branch;
  logic        ex_br_taken;
  logic [31:0] ex_br_target;
  logic        flush;
  logic [31:0] redirect_pc;
  logic        br;
  logic        brTaken;
  logic [31:0] update_br_target;
  logic [1:0]  w_index;
  logic        pr_correct;

  modport master (
    output stall, if_valid, if_pc, if_take_br, if_br_target, if_index,
    output ex_is_branch, ex_br_taken, ex_br_target,
    input  flush, redirect_pc, br, brTaken, update_br_target, w_index, pr_correct
  );

  modport slave (
    input  stall, if_valid, if_pc, if_take_br, if_br_target, if_index,
    input  ex_is_branch, ex_br_taken, ex_br_target,
    output flush, redirect_pc, br, brTaken, update_br_target, w_index, pr_correct
  );
endinterface

// File: rtl/br_resolve.sv
// Branch resolution unit: carries fetch-time predictions to EX, detects mispredicts,
// raises flush/redirect and drives the predictor's registered training port.
module br_resolve #(
  parameter int CNT_W = 16
) (
  input  logic             CLK,
  input  logic             nRST,
  br_resolve_if.slave      bif,
  input  logic             cnt_clr,
  output logic [CNT_W-1:0] br_count,
  output logic [CNT_W-1:0] miss_count
);

  logic        vld_p0, take_p0;
  logic [31:0] pc_p0, tgt_p0;
  logic [1:0]  idx_p0;
  logic        vld_p1, take_p1;
  logic [31:0] pc_p1, tgt_p1;
  logic [1:0]  idx_p1;
  logic        vld_p2, taken_p2, correct_p2;
  logic [31:0] tgt_p2;
  logic [1:0]  idx_p2;
  logic        fire, mispredict;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (&c) ? c : c + CNT_W'(1);
  endfunction

  assign fire       = vld_p1 & bif.ex_is_branch & ~bif.stall;
  assign mispredict = fire & ((take_p1 != bif.ex_br_taken) |
                              (bif.ex_br_taken & take_p1 & (tgt_p1 != bif.ex_br_target)));

  assign bif.flush       = mispredict;
  assign bif.redirect_pc = !mispredict      ? 32'd0 :
                           bif.ex_br_taken ? bif.ex_br_target : pc_p1 + 32'd4;

  // p0 = DE, p1 = EX: valids are control and are reset / killed by a flush
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      vld_p0 <= 1'b0;
      vld_p1 <= 1'b0;
    end else if (!bif.stall) begin
      vld_p0 <= bif.if_valid & ~mispredict;
      vld_p1 <= vld_p0 & ~mispredict;
    end
  end

  always_ff @(posedge CLK) begin
    if (!bif.stall) begin
      pc_p0   <= bif.if_pc;
      take_p0 <= bif.if_take_br;
      tgt_p0  <= bif.if_br_target;
      idx_p0  <= bif.if_index;
      pc_p1   <= pc_p0;
      take_p1 <= take_p0;
      tgt_p1  <= tgt_p0;
      idx_p1  <= idx_p0;
    end
  end

  // p2 = predictor training register, loaded every cycle regardless of stall
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      vld_p2     <= 1'b0;
      taken_p2   <= 1'b0;
      tgt_p2     <= 32'd0;
      idx_p2     <= 2'd0;
      correct_p2 <= 1'b0;
    end else begin
      vld_p2     <= fire;
      taken_p2   <= bif.ex_br_taken;
      tgt_p2     <= bif.ex_br_target;
      idx_p2     <= idx_p1;
      correct_p2 <= ~mispredict;
    end
  end

  assign bif.br               = vld_p2;
  assign bif.brTaken          = taken_p2;
  assign bif.update_br_target = tgt_p2;
  assign bif.w_index          = idx_p2;
  assign bif.pr_correct       = correct_p2;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      br_count   <= '0;
      miss_count <= '0;
    end else if (cnt_clr) begin
      br_count   <= '0;
      miss_count <= '0;
    end else begin
      if (fire)       br_count   <= sat_inc(br_count);
      if (mispredict) miss_count <= sat_inc(miss_count);
    end
  end

endmodule
